// File: rtl/ps2_kbd_digits_if.sv
// PS/2 pins plus the nibble/pulse outputs that feed the hex display path.
interface ps2_kbd_digits_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [3:0] code_hi;
    logic [3:0] code_lo;
    logic       code_en;
    logic [3:0] cnt_hi;
    logic [3:0] cnt_lo;
    logic       byte_valid;
    logic       frame_err;

    modport master (
        output ps2_clk, ps2_data,
        input  code_hi, code_lo, code_en, cnt_hi, cnt_lo, byte_valid, frame_err
    );

    modport slave (
        input  ps2_clk, ps2_data,
        output code_hi, code_lo, code_en, cnt_hi, cnt_lo, byte_valid, frame_err
    );
endinterface

// File: rtl/ps2_kbd_digits.sv
// PS/2 keyboard receiver with make/break tracking and an 8-bit press counter,
// presenting scan code and count as hex nibbles for four seven-segment digits.
module ps2_kbd_digits #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             rst_n,
    ps2_kbd_digits_if.slave  bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BREAK = 1'b1
    } state_t;

    // Odd parity: data bits plus parity bit must contain an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return (^data) ^ par;
    endfunction

    logic clk_s1_r, clk_s2_r, clk_prev_r;
    logic dat_s1_r, dat_s2_r;
    logic fall_s;

    // Two-flop synchronisers plus one history flop for edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clk_s1_r   <= 1'b1;
            clk_s2_r   <= 1'b1;
            clk_prev_r <= 1'b1;
            dat_s1_r   <= 1'b1;
            dat_s2_r   <= 1'b1;
        end else begin
            clk_s1_r   <= bus.ps2_clk;
            clk_s2_r   <= clk_s1_r;
            clk_prev_r <= clk_s2_r;
            dat_s1_r   <= bus.ps2_data;
            dat_s2_r   <= dat_s1_r;
        end
    end

    assign fall_s = clk_prev_r & ~clk_s2_r;

    logic [3:0]    bit_cnt_r;
    logic [9:0]    shift_r;
    logic [10:0]   frame_s;
    logic [TW-1:0] tmo_cnt_r;
    logic [7:0]    byte_r;
    logic          byte_valid_r;
    logic          frame_err_r;
    logic          frame_ok_s;

    // frame_s is the full 11-bit frame as it stands once the current bit lands
    assign frame_s    = {dat_s2_r, shift_r};
    assign frame_ok_s = ~frame_s[0] & frame_s[10] & odd_parity_ok(frame_s[8:1], frame_s[9]);

    // Frame receiver with mid-frame idle timeout; a falling edge beats a timeout
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt_r    <= 4'd0;
            shift_r      <= 10'd0;
            tmo_cnt_r    <= {TW{1'b0}};
            byte_r       <= 8'd0;
            byte_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            byte_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
            if (fall_s) begin
                tmo_cnt_r <= {TW{1'b0}};
                shift_r   <= frame_s[10:1];
                if (bit_cnt_r == 4'd10) begin
                    bit_cnt_r <= 4'd0;
                    if (frame_ok_s) begin
                        byte_r       <= frame_s[8:1];
                        byte_valid_r <= 1'b1;
                    end else begin
                        frame_err_r  <= 1'b1;
                    end
                end else begin
                    bit_cnt_r <= bit_cnt_r + 4'd1;
                end
            end else if (tmo_cnt_r == TMO_MAX) begin
                bit_cnt_r <= 4'd0;
            end else begin
                tmo_cnt_r <= tmo_cnt_r + TW'(1);
            end
        end
    end

    state_t     state_r, state_nxt_s;
    logic [7:0] code_r, code_nxt_s;
    logic [7:0] cnt_r, cnt_nxt_s;
    logic       code_en_r, code_en_nxt_s;

    // Decoder state and display registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            code_r    <= 8'd0;
            cnt_r     <= 8'd0;
            code_en_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            code_r    <= code_nxt_s;
            cnt_r     <= cnt_nxt_s;
            code_en_r <= code_en_nxt_s;
        end
    end

    // Make/break decode; a repeated make of the held key is typematic, not a press
    always_comb begin
        state_nxt_s   = state_r;
        code_nxt_s    = code_r;
        cnt_nxt_s     = cnt_r;
        code_en_nxt_s = code_en_r;
        if (byte_valid_r) begin
            case (state_r)
                IDLE: begin
                    if (byte_r == 8'hF0) begin
                        state_nxt_s = BREAK;
                    end else if (byte_r == 8'hE0) begin
                        state_nxt_s = IDLE;
                    end else if (!code_en_r || (byte_r != code_r)) begin
                        code_nxt_s    = byte_r;
                        code_en_nxt_s = 1'b1;
                        cnt_nxt_s     = cnt_r + 8'd1;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                BREAK: begin
                    state_nxt_s = IDLE;
                    if (byte_r == code_r) begin
                        code_en_nxt_s = 1'b0;
                    end else begin
                        code_en_nxt_s = code_en_r;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    assign bus.code_hi    = code_r[7:4];
    assign bus.code_lo    = code_r[3:0];
    assign bus.code_en    = code_en_r;
    assign bus.cnt_hi     = cnt_r[7:4];
    assign bus.cnt_lo     = cnt_r[3:0];
    assign bus.byte_valid = byte_valid_r;
    assign bus.frame_err  = frame_err_r;
endmodule

// File: tb/tb_ps2_kbd_digits.sv
// Directed bench for ps2_kbd_digits: pulse kinds go through a scoreboard queue,
// display outputs are compared against values worked out from the key sequence.
module tb_ps2_kbd_digits;
    localparam int TMO = 200;
    localparam int PH  = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ps2_kbd_digits_if bus();

    ps2_kbd_digits #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic       err;
        logic [7:0] b;
    } exp_t;

    exp_t exp_q[$];
    exp_t want;

    // Scoreboard: every pulse must match the oldest outstanding frame
    always @(negedge clk) begin
        if (bus.byte_valid === 1'b1 || bus.frame_err === 1'b1) begin
            vectors++;
            assert (exp_q.size() != 0) else begin
                miscompares++;
                $error("FAIL unexpected_pulse: byte_valid=%b frame_err=%b, expected no pulse",
                       bus.byte_valid, bus.frame_err);
            end
            if (exp_q.size() != 0) begin
                want = exp_q.pop_front();
                vectors++;
                assert ({bus.frame_err, bus.byte_valid} === {want.err, ~want.err}) else begin
                    miscompares++;
                    $error("FAIL pulse_kind(%h): frame_err/byte_valid=%b%b, expected %b%b",
                           want.b, bus.frame_err, bus.byte_valid, want.err, ~want.err);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ps2_bit(input logic v);
        bus.ps2_data = v;
        tick(PH);
        bus.ps2_clk = 1'b0;
        tick(PH);
        bus.ps2_clk = 1'b1;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            tick(1);
            n++;
        end
        vectors++;
        assert (exp_q.size() == 0) else begin
            miscompares++;
            $error("FAIL pulse_timeout: %0d frames without pulse, expected 0", exp_q.size());
            exp_q.delete();
        end
        tick(3);
    endtask

    // kind: 0 good, 1 bad parity, 2 stop bit 0, 3 abandon after 5 bits (gap = idle time)
    task automatic send_frame(input logic [7:0] b, input int kind, input int gap);
        logic [10:0] fr;
        logic        par;
        logic        stp;
        exp_t        e;
        par = ~^b;
        stp = 1'b1;
        if (kind == 1) par = ~par;
        if (kind == 2) stp = 1'b0;
        fr = {stp, par, b, 1'b0};
        if (kind != 3) begin
            e.err = (kind != 0);
            e.b   = b;
            exp_q.push_back(e);
        end
        for (int i = 0; i < 11; i++) begin
            if (i == 5 && gap > 0) tick(gap);
            if (kind == 3 && i == 5) break;
            ps2_bit(fr[i]);
        end
        bus.ps2_data = 1'b1;
        wait_drain();
    endtask

    task automatic check_out(input string tag, input logic [7:0] code,
                             input logic en, input logic [7:0] cnt);
        vectors++;
        assert ({bus.code_hi, bus.code_lo, bus.code_en, bus.cnt_hi, bus.cnt_lo,
                 bus.byte_valid, bus.frame_err} === {code, en, cnt, 2'b00}) else begin
            miscompares++;
            $error("FAIL %s: code=%h%h en=%b cnt=%h%h pulses=%b%b, expected code=%h en=%b cnt=%h pulses=00",
                   tag, bus.code_hi, bus.code_lo, bus.code_en, bus.cnt_hi, bus.cnt_lo,
                   bus.byte_valid, bus.frame_err, code, en, cnt);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] key;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(2);
        check_out("reset", 8'h00, 1'b0, 8'h00);

        send_frame(8'h1C, 0, 0);
        check_out("single_make", 8'h1C, 1'b1, 8'h01);
        send_frame(8'h1C, 0, 0);
        send_frame(8'h1C, 0, 0);
        check_out("typematic", 8'h1C, 1'b1, 8'h01);
        send_frame(8'hF0, 0, 0);
        check_out("break_prefix", 8'h1C, 1'b1, 8'h01);
        send_frame(8'h1C, 0, 0);
        check_out("break", 8'h1C, 1'b0, 8'h01);

        do_reset();
        send_frame(8'h1C, 0, 0);
        send_frame(8'h32, 0, 0);
        check_out("overlap_make", 8'h32, 1'b1, 8'h02);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h1C, 0, 0);
        check_out("break_other", 8'h32, 1'b1, 8'h02);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h32, 0, 0);
        check_out("break_held", 8'h32, 1'b0, 8'h02);
        send_frame(8'hE0, 0, 0);
        check_out("ext_prefix", 8'h32, 1'b0, 8'h02);
        send_frame(8'h75, 0, 0);
        check_out("ext_make", 8'h75, 1'b1, 8'h03);

        send_frame(8'h1C, 1, 0);
        check_out("bad_parity", 8'h75, 1'b1, 8'h03);
        send_frame(8'h1C, 2, 0);
        check_out("bad_stop", 8'h75, 1'b1, 8'h03);
        send_frame(8'h1C, 3, TMO + 20);
        check_out("timeout_idle", 8'h75, 1'b1, 8'h03);
        send_frame(8'h2A, 0, 0);
        check_out("after_timeout", 8'h2A, 1'b1, 8'h04);
        send_frame(8'h3B, 0, TMO - 100);
        check_out("gap_below_timeout", 8'h3B, 1'b1, 8'h05);

        do_reset();
        bus.ps2_data = 1'b0;
        ps2_bit(1'b0);
        for (int i = 0; i < 6; i++) ps2_bit(i[0]);
        bus.ps2_data = 1'b1;
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(2);
        check_out("mid_frame_reset", 8'h00, 1'b0, 8'h00);
        send_frame(8'h1C, 0, 0);
        check_out("after_reset", 8'h1C, 1'b1, 8'h01);

        do_reset();
        for (int p = 0; p < 256; p++) begin
            key = p[0] ? 8'h32 : 8'h1C;
            send_frame(key, 0, 0);
            if (p == 254) check_out("count_ff", key, 1'b1, 8'hFF);
            if (p == 255) check_out("count_wrap", key, 1'b1, 8'h00);
            send_frame(8'hF0, 0, 0);
            send_frame(key, 0, 0);
        end
        check_out("wrap_released", 8'h32, 1'b0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
